kf_spi_master: RTL and testbench
================================

KF_SPI_MASTER -- requirements
Module: kf_spi_master

Interface
REQ-001 Parameter DATA_W, 16, bits per SPI word, both config and readback.
REQ-002 Parameter CLK_DIV, 4, SCLK half-period in clk cycles; legal values are 2 or more.
REQ-003 Parameter GAP_CYC, 4, idle clk cycles between words with SCLK low.
REQ-004 Ports, in this order:
- clk  in  1  system clock.
- n_rst  in  1  asynchronous active-low reset.
- cfg_start  in  1  pulse that begins the configuration sequence.
- acc_cfg, gyro_cfg, mag_cfg, dec_cfg, dt_cfg  in  DATA_W each  config words.
- read_en  in  1  level; while high and configured, readback is serviced.
- output_ready_in  in  1  slave data-available flag.
- miso_in  in  1  slave serial data.
- sclk_out  out  1  SPI clock.
- mosi_out  out  1  SPI data to the slave.
- ss_out  out  1  slave select, active high.
- busy_out  out  1  high in any state except IDLE.
- configured_out  out  1  sticky flag: all five words sent.
- rd_data_out  out  DATA_W  last word read back.
- rd_valid_out  out  1  one-cycle pulse when rd_data_out updates.

Function
REQ-005 States: IDLE, START, SHIFT_CFG, GAP, WAIT_READY, SHIFT_RD, DONE.
REQ-006 IDLE:
- cfg_start=1 and configured=0: latch all five cfg inputs, clear word index to 0, go to START.
- Otherwise read_en=1 and configured=1: go to WAIT_READY.
- cfg_start has priority over read_en.
REQ-007 START: ss=1, mosi=1, sclk=0 for 2*CLK_DIV cycles, then go to SHIFT_CFG.
REQ-008 SHIFT_CFG: emits DATA_W SCLK periods, MSB first, word order acc, gyro, mag, dec, dt.
- mosi changes only while sclk is low.
- Each bit is held for CLK_DIV cycles before the rising edge.
REQ-009 After the DATA_W-th falling edge, go to GAP for GAP_CYC cycles with ss=1, sclk=0.
- If index<4: increment index, return to SHIFT_CFG.
- Else: set configured, go to DONE.
REQ-010 WAIT_READY: ss=1, sclk=0, wait for output_ready_in=1, then go to SHIFT_RD.
REQ-011 SHIFT_RD: emits DATA_W SCLK periods.
- Sample miso_in on each rising edge and shift MSB first.
- After the DATA_W-th falling edge, load rd_data_out, pulse rd_valid_out, go to DONE.
REQ-012 DONE: ss=1 for one cycle, then ss=0 for GAP_CYC cycles, then go to IDLE.
REQ-013 ss stays high from START through the end of DONE's first cycle, so the slave never sees ss=0 mid-transfer.
REQ-014 cfg_start while busy is ignored; read_en deasserting mid-SHIFT_RD does not abort the word.
REQ-015 cfg_start with configured=1 is ignored; configuration is sent once per reset.
REQ-016 A single bit counter wraps at DATA_W, and the divider counter restarts on every state entry.

Reset
REQ-017 On n_rst=0, immediately:
- state=IDLE, sclk=0, mosi=0, ss=0, busy=0, configured=0.
- rd_data=0, rd_valid=0.
- All counters and the latched config words are 0.
REQ-018 Reset mid-transfer aborts with no partial rd_valid pulse; a new cfg_start after release resends all five words.

Configuration
REQ-019 Macro KF_SPI_MASTER_TIMEOUT_EN.
- Defined: WAIT_READY counts clk cycles; at 4096 without output_ready_in, go to DONE with no rd_valid, and timeout_out (out, 1) pulses for one cycle.
- Undefined: timeout_out port and counter are absent, and WAIT_READY waits indefinitely.

Structure
REQ-020 Package kf_spi_pkg holds:
- The state enum type.
- NUM_CFG=5.
- The default DATA_W, CLK_DIV and GAP_CYC constants.
REQ-021 One sub-module, kf_sclk_gen: takes an enable, generates sclk, and emits one-cycle rise and fall strobes.

Verification
REQ-022 Config words 0x1234, 0xABCD, 0x00FF, 0x8001, 0x0F0F with DATA_W=16, CLK_DIV=4: slave model captures the same five words in order, and configured=1 after the 5th GAP.
REQ-023 Check the START pulse: mosi=1, sclk=0 for exactly 8 clk cycles before the first rising edge.
REQ-024 Configured, read_en=1, slave raises output_ready and shifts 0xC3A5: rd_data=0xC3A5, rd_valid is a single-cycle pulse, and exactly 16 falling edges occur.
REQ-025 Assert n_rst=0 at bit 7 of the gyro word: all outputs are 0 immediately; after release, cfg_start resends from the acc word.
REQ-026 cfg_start held during SHIFT_RD and asserted again after configured=1: no new START, and no mosi activity.
REQ-027 With KF_SPI_MASTER_TIMEOUT_EN, output_ready held at 0: timeout_out pulses at cycle 4096 and the FSM returns to IDLE.

Source files
------------

// File: rtl/kf_spi_pkg.sv
// kf_spi_pkg
//   Shared types and constants for the kf_spi_master configuration/readback
//   SPI master and its SCLK generator.
//   - spi_state_t : master FSM state encoding
//   - NUM_CFG     : number of configuration words sent after cfg_start
//   - DEF_*       : default DATA_W / CLK_DIV / GAP_CYC parameter values
//   - TIMEOUT_CYC : WAIT_READY watchdog length (KF_SPI_MASTER_TIMEOUT_EN builds)
package kf_spi_pkg;

  localparam int NUM_CFG     = 5;
  localparam int DEF_DATA_W  = 16;
  localparam int DEF_CLK_DIV = 4;
  localparam int DEF_GAP_CYC = 4;
  localparam int TIMEOUT_CYC = 4096;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_SHIFT_CFG,
    ST_GAP,
    ST_WAIT_READY,
    ST_SHIFT_RD,
    ST_DONE
  } spi_state_t;

endpackage

// File: rtl/kf_sclk_gen.sv
// kf_sclk_gen
//   SPI clock generator. While en is high, sclk_out toggles every CLK_DIV
//   clk cycles, starting with a full low half-period. While en is low,
//   sclk_out is held low and the half-period counter is reloaded, so each
//   enable starts a fresh low phase.
//   Ports:
//     clk, n_rst          system clock, async active-low reset
//     en                  run the clock
//     sclk_out            SPI clock (registered)
//     rise_stb, fall_stb  one-cycle strobes, high in the cycle whose closing
//                         clk edge makes sclk_out rise / fall
module kf_sclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic n_rst,
  input  logic en,
  output logic sclk_out,
  output logic rise_stb,
  output logic fall_stb
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] HALF_LD = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic             edge_due;

  // Strobes lead the sclk edge by one cycle so the master can update mosi
  // on the same clk edge as the falling sclk edge.
  assign edge_due = en && (cnt == '0);
  assign rise_stb = edge_due && !sclk_out;
  assign fall_stb = edge_due && sclk_out;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sclk_out <= 1'b0;
      cnt      <= '0;
    end else if (!en) begin
      sclk_out <= 1'b0;
      cnt      <= HALF_LD;
    end else if (cnt == '0) begin
      sclk_out <= ~sclk_out;
      cnt      <= HALF_LD;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/kf_spi_master.sv
// kf_spi_master
//   SPI master for a sensor front end. After cfg_start it sends five latched
//   configuration words (acc, gyro, mag, dec, dt) once per reset, then, while
//   read_en is high, reads one DATA_W word per output_ready_in request.
//   Ports:
//     clk, n_rst                         system clock, async active-low reset
//     cfg_start                          begin configuration (ignored if busy
//                                        or already configured)
//     acc/gyro/mag/dec/dt_cfg            configuration words
//     read_en, output_ready_in, miso_in  readback control and slave data
//     sclk_out, mosi_out, ss_out         SPI bus (ss active high)
//     busy_out, configured_out           status
//     rd_data_out, rd_valid_out          last readback word and its strobe
//     timeout_out                        WAIT_READY watchdog pulse
//                                        (KF_SPI_MASTER_TIMEOUT_EN only)
//   Build option: define KF_SPI_MASTER_TIMEOUT_EN to add a 4096-cycle
//   watchdog on WAIT_READY; otherwise WAIT_READY waits indefinitely.
//
//   state         | meaning
//   --------------+------------------------------------------------------
//   ST_IDLE       | ss low, waiting for cfg_start or read_en
//   ST_START      | ss=1, mosi=1, sclk low for 2*CLK_DIV cycles
//   ST_SHIFT_CFG  | shifting config word idx out MSB first
//   ST_GAP        | GAP_CYC idle cycles between config words, ss held
//   ST_WAIT_READY | ss high, waiting for the slave's output_ready_in
//   ST_SHIFT_RD   | shifting one readback word in from miso
//   ST_DONE       | one cycle ss=1, then GAP_CYC cycles ss=0
module kf_spi_master
  import kf_spi_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int GAP_CYC = DEF_GAP_CYC
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              cfg_start,
  input  logic [DATA_W-1:0] acc_cfg,
  input  logic [DATA_W-1:0] gyro_cfg,
  input  logic [DATA_W-1:0] mag_cfg,
  input  logic [DATA_W-1:0] dec_cfg,
  input  logic [DATA_W-1:0] dt_cfg,
  input  logic              read_en,
  input  logic              output_ready_in,
  input  logic              miso_in,
  output logic              sclk_out,
  output logic              mosi_out,
  output logic              ss_out,
  output logic              busy_out,
  output logic              configured_out,
  output logic [DATA_W-1:0] rd_data_out,
  output logic              rd_valid_out
`ifdef KF_SPI_MASTER_TIMEOUT_EN
  ,
  output logic              timeout_out
`endif
);

  localparam int BIT_W   = $clog2(DATA_W);
  localparam int TMR_MAX = (2 * CLK_DIV - 1 > GAP_CYC) ? (2 * CLK_DIV - 1) : GAP_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
  localparam logic [2:0]       LAST_IDX = 3'(NUM_CFG - 1);
  localparam logic [TMR_W-1:0] START_LD = TMR_W'(2 * CLK_DIV - 1);
  localparam logic [TMR_W-1:0] GAP_LD   = TMR_W'(GAP_CYC - 1);
  // DONE spans one ss-high cycle plus GAP_CYC ss-low cycles.
  localparam logic [TMR_W-1:0] DONE_LD  = TMR_W'(GAP_CYC);

`ifdef KF_SPI_MASTER_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC);
  localparam logic [WD_W-1:0] WD_LD = WD_W'(TIMEOUT_CYC - 1);
  logic [WD_W-1:0] wdog;
`endif

  spi_state_t        state;
  logic [TMR_W-1:0]  tmr;
  logic [BIT_W-1:0]  bit_cnt;
  logic [2:0]        idx;
  logic [DATA_W-1:0] cfg_q [NUM_CFG];
  logic [DATA_W-1:0] tx_sh;
  logic [DATA_W-1:0] rx_sh;
  logic [DATA_W-1:0] nxt_word;
  logic              sclk_en;
  logic              rise_stb;
  logic              fall_stb;
  logic              last_bit;

  assign sclk_en  = (state == ST_SHIFT_CFG) || (state == ST_SHIFT_RD);
  assign last_bit = (bit_cnt == LAST_BIT);
  assign nxt_word = cfg_q[idx + 3'd1];

  kf_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .clk      (clk),
    .n_rst    (n_rst),
    .en       (sclk_en),
    .sclk_out (sclk_out),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state          <= ST_IDLE;
      mosi_out       <= 1'b0;
      ss_out         <= 1'b0;
      busy_out       <= 1'b0;
      configured_out <= 1'b0;
      rd_data_out    <= '0;
      rd_valid_out   <= 1'b0;
      tmr            <= '0;
      bit_cnt        <= '0;
      idx            <= '0;
      tx_sh          <= '0;
      rx_sh          <= '0;
      for (int i = 0; i < NUM_CFG; i++) cfg_q[i] <= '0;
`ifdef KF_SPI_MASTER_TIMEOUT_EN
      wdog           <= '0;
      timeout_out    <= 1'b0;
`endif
    end else begin
      rd_valid_out <= 1'b0;
`ifdef KF_SPI_MASTER_TIMEOUT_EN
      timeout_out  <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (cfg_start && !configured_out) begin
            cfg_q[0] <= acc_cfg;
            cfg_q[1] <= gyro_cfg;
            cfg_q[2] <= mag_cfg;
            cfg_q[3] <= dec_cfg;
            cfg_q[4] <= dt_cfg;
            idx      <= '0;
            tmr      <= START_LD;
            ss_out   <= 1'b1;
            mosi_out <= 1'b1;
            busy_out <= 1'b1;
            state    <= ST_START;
          end else if (read_en && configured_out) begin
            ss_out   <= 1'b1;
            busy_out <= 1'b1;
`ifdef KF_SPI_MASTER_TIMEOUT_EN
            wdog     <= WD_LD;
`endif
            state    <= ST_WAIT_READY;
          end
        end

        ST_START: begin
          if (tmr == '0) begin
            mosi_out <= cfg_q[0][DATA_W-1];
            tx_sh    <= {cfg_q[0][DATA_W-2:0], 1'b0};
            bit_cnt  <= '0;
            state    <= ST_SHIFT_CFG;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end

        ST_SHIFT_CFG: begin
          if (fall_stb) begin
            if (last_bit) begin
              bit_cnt  <= '0;
              mosi_out <= 1'b0;
              tmr      <= GAP_LD;
              state    <= ST_GAP;
            end else begin
              bit_cnt  <= bit_cnt + 1'b1;
              mosi_out <= tx_sh[DATA_W-1];
              tx_sh    <= {tx_sh[DATA_W-2:0], 1'b0};
            end
          end
        end

        ST_GAP: begin
          if (tmr != '0) begin
            tmr <= tmr - 1'b1;
          end else if (idx < LAST_IDX) begin
            idx      <= idx + 3'd1;
            mosi_out <= nxt_word[DATA_W-1];
            tx_sh    <= {nxt_word[DATA_W-2:0], 1'b0};
            state    <= ST_SHIFT_CFG;
          end else begin
            configured_out <= 1'b1;
            tmr            <= DONE_LD;
            state          <= ST_DONE;
          end
        end

        ST_WAIT_READY: begin
          if (output_ready_in) begin
            bit_cnt <= '0;
            state   <= ST_SHIFT_RD;
          end
`ifdef KF_SPI_MASTER_TIMEOUT_EN
          else if (wdog == '0) begin
            timeout_out <= 1'b1;
            tmr         <= DONE_LD;
            state       <= ST_DONE;
          end else begin
            wdog <= wdog - 1'b1;
          end
`endif
        end

        ST_SHIFT_RD: begin
          if (rise_stb) rx_sh <= {rx_sh[DATA_W-2:0], miso_in};
          if (fall_stb) begin
            if (last_bit) begin
              bit_cnt      <= '0;
              rd_data_out  <= rx_sh;
              rd_valid_out <= 1'b1;
              tmr          <= DONE_LD;
              state        <= ST_DONE;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end

        ST_DONE: begin
          ss_out <= 1'b0;
          if (tmr == '0) begin
            busy_out <= 1'b0;
            state    <= ST_IDLE;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kf_spi_master.sv
// tb_kf_spi_master
//   Self-checking bench for kf_spi_master with DATA_W=16, CLK_DIV=4,
//   GAP_CYC=4. A slave model captures mosi words on sclk rising edges while
//   ss is high and drives miso MSB first, changing after each falling edge.
//   Build option KF_SPI_MASTER_TIMEOUT_EN adds the watchdog test.
module tb_kf_spi_master;

  localparam int DW = 16;
  localparam int CD = 4;
  localparam int GC = 4;
  localparam int NW = 5;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic          cfg_start = 1'b0;
  logic [DW-1:0] acc_cfg = '0, gyro_cfg = '0, mag_cfg = '0, dec_cfg = '0, dt_cfg = '0;
  logic          read_en = 1'b0;
  logic          output_ready_in = 1'b0;
  logic          miso_in;
  logic          sclk_out, mosi_out, ss_out, busy_out, configured_out, rd_valid_out;
  logic [DW-1:0] rd_data_out;
`ifdef KF_SPI_MASTER_TIMEOUT_EN
  logic          timeout_out;
`endif

  always #5 clk = ~clk;

  kf_spi_master #(.DATA_W(DW), .CLK_DIV(CD), .GAP_CYC(GC)) dut (
    .clk             (clk),
    .n_rst           (n_rst),
    .cfg_start       (cfg_start),
    .acc_cfg         (acc_cfg),
    .gyro_cfg        (gyro_cfg),
    .mag_cfg         (mag_cfg),
    .dec_cfg         (dec_cfg),
    .dt_cfg          (dt_cfg),
    .read_en         (read_en),
    .output_ready_in (output_ready_in),
    .miso_in         (miso_in),
    .sclk_out        (sclk_out),
    .mosi_out        (mosi_out),
    .ss_out          (ss_out),
    .busy_out        (busy_out),
    .configured_out  (configured_out),
    .rd_data_out     (rd_data_out),
    .rd_valid_out    (rd_valid_out)
`ifdef KF_SPI_MASTER_TIMEOUT_EN
    ,
    .timeout_out     (timeout_out)
`endif
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // ---------------- slave model ----------------
  logic [DW-1:0] cap_sh = '0;
  int            cap_bits = 0;
  logic [DW-1:0] cap_q [$];
  int            rise_cnt = 0;
  int            fall_cnt = 0;
  logic [DW-1:0] slv_word = '0;
  int            slv_base = 0;

  always @(posedge sclk_out or negedge n_rst) begin
    if (!n_rst) begin
      cap_bits = 0;
      cap_sh   = '0;
    end else if (ss_out) begin
      rise_cnt++;
      cap_sh = {cap_sh[DW-2:0], mosi_out};
      cap_bits++;
      if (cap_bits == DW) begin
        cap_q.push_back(cap_sh);
        cap_bits = 0;
      end
    end
  end

  always @(negedge sclk_out) fall_cnt++;

  always_comb begin
    int d;
    d = fall_cnt - slv_base;
    miso_in = (d >= 0 && d < DW) ? slv_word[DW-1-d] : 1'b0;
  end

  // ---------------- output monitor (1ns after each clk edge) ----------------
  int            rv_cycles = 0, rv_pulses = 0, mosi_hi = 0, busy_hi = 0, ss_rises = 0;
  int            ss_run = 0, last_ss_run = 0;
  logic          rv_prev = 1'b0, ss_prev = 1'b0;
  logic [DW-1:0] rv_last = '0;

  always @(posedge clk) begin
    #1;
    if (rd_valid_out) begin
      rv_cycles++;
      rv_last = rd_data_out;
      if (!rv_prev) rv_pulses++;
    end
    rv_prev = rd_valid_out;
    if (mosi_out) mosi_hi++;
    if (busy_out) busy_hi++;
    if (ss_out && !ss_prev) ss_rises++;
    if (ss_out) ss_run++;
    else begin
      if (ss_prev) last_ss_run = ss_run;
      ss_run = 0;
    end
    ss_prev = ss_out;
  end

  // Behavioural expectation: the slave presents its bits MSB first and the
  // master assembles them in arrival order.
  function automatic logic [DW-1:0] model_read(input logic [DW-1:0] w);
    logic          bits [$];
    logic [DW-1:0] r;
    for (int i = DW - 1; i >= 0; i--) bits.push_back(w[i]);
    r = '0;
    foreach (bits[i]) r = {r[DW-2:0], bits[i]};
    return r;
  endfunction

  typedef struct {
    logic [DW-1:0] word;
    int            pre_wait;
    logic [DW-1:0] exp_rd;
  } rd_vec_t;

  rd_vec_t       vecs [8];
  logic [DW-1:0] cfg_w [NW];

  task automatic set_cfg();
    acc_cfg  = cfg_w[0];
    gyro_cfg = cfg_w[1];
    mag_cfg  = cfg_w[2];
    dec_cfg  = cfg_w[3];
    dt_cfg   = cfg_w[4];
  endtask

  task automatic pulse_cfg_start();
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
  endtask

  task automatic wait_configured(input string nm);
    int k;
    for (k = 0; k < 3000 && !configured_out; k++) @(negedge clk);
    chk({nm, "_cfg_wait"}, 32'(k < 3000), 1);
    for (k = 0; k < 50 && busy_out; k++) @(negedge clk);
    chk({nm, "_idle_wait"}, 32'(k < 50), 1);
  endtask

  task automatic check_words(input string nm, input int base);
    chk({nm, "_word_count"}, 32'(cap_q.size() - base), NW);
    for (int i = 0; i < NW; i++)
      if (base + i < cap_q.size()) chk($sformatf("%s_word%0d", nm, i), 32'(cap_q[base+i]), 32'(cfg_w[i]));
  endtask

  task automatic do_read(input logic [DW-1:0] w, input int pre_wait, output logic [DW-1:0] got,
                         output int falls, output int pulses, output int hicyc);
    int k, p0, h0;
    slv_word = w;
    slv_base = fall_cnt;
    p0 = rv_pulses;
    h0 = rv_cycles;
    read_en = 1'b1;
    for (k = 0; k < 10 && !busy_out; k++) @(negedge clk);
    chk("read_busy_wait", 32'(busy_out), 1);
    repeat (pre_wait) @(negedge clk);
    output_ready_in = 1'b1;
    for (k = 0; k < 400 && rv_pulses == p0; k++) @(negedge clk);
    chk("read_valid_wait", 32'(k < 400), 1);
    output_ready_in = 1'b0;
    read_en = 1'b0;
    for (k = 0; k < 20 && busy_out; k++) @(negedge clk);
    chk("read_idle_wait", 32'(busy_out), 0);
    got    = rv_last;
    falls  = fall_cnt - slv_base;
    pulses = rv_pulses - p0;
    hicyc  = rv_cycles - h0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int            t, run, k, base, m0, s0, b0, p0, f0, r0;
    int            falls, pulses, hicyc;
    logic [DW-1:0] got;

    // ---- reset state ----
    #12;
    chk("reset_ctrl_outputs", 32'({sclk_out, mosi_out, ss_out, busy_out, configured_out, rd_valid_out}), 0);
    chk("reset_rd_data", 32'(rd_data_out), 0);
    @(negedge clk);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);

    // ---- fixed configuration words and START pulse shape ----
    cfg_w[0] = 16'h1234; cfg_w[1] = 16'hABCD; cfg_w[2] = 16'h00FF;
    cfg_w[3] = 16'h8001; cfg_w[4] = 16'h0F0F;
    set_cfg();
    base = cap_q.size();
    pulse_cfg_start();
    chk("start_ss_high", 32'(ss_out), 1);
    t = 0; run = 0;
    while (!sclk_out && t < 100) begin
      if (ss_out && mosi_out && run == t) run++;
      t++;
      @(negedge clk);
    end
    chk("start_mosi_high_cycles", 32'(run), 2 * CD);
    chk("first_rise_delay", 32'(t), 3 * CD);
    for (k = 0; k < 3000 && !configured_out; k++) @(negedge clk);
    chk("configured_wait", 32'(k < 3000), 1);
    chk("configured_in_done_first_cycle", 32'(ss_out), 1);
    for (k = 0; k < 50 && busy_out; k++) @(negedge clk);
    chk("config_idle", 32'(busy_out), 0);
    check_words("fixed_cfg", base);
    chk("config_frame_ss_cycles", 32'(last_ss_run), 2 * CD + NW * (DW * 2 * CD + GC) + 1);

    // ---- readback table ----
    vecs[0] = '{16'hC3A5, 0, 16'h0};
    vecs[1] = '{16'h0000, 2, 16'h0};
    vecs[2] = '{16'hFFFF, 1, 16'h0};
    vecs[3] = '{16'h8001, 3, 16'h0};
    for (int i = 4; i < 8; i++) vecs[i] = '{DW'($urandom), int'($urandom_range(0, 6)), 16'h0};
    foreach (vecs[i]) vecs[i].exp_rd = model_read(vecs[i].word);
    for (int i = 0; i < 8; i++) begin
      do_read(vecs[i].word, vecs[i].pre_wait, got, falls, pulses, hicyc);
      chk($sformatf("read%0d_data", i), 32'(got), 32'(vecs[i].exp_rd));
      chk($sformatf("read%0d_falls", i), 32'(falls), DW);
      chk($sformatf("read%0d_valid_pulses", i), 32'(pulses), 1);
      chk($sformatf("read%0d_valid_cycles", i), 32'(hicyc), 1);
    end

    // ---- cfg_start during readback and after configuration ----
    m0 = mosi_hi; s0 = ss_rises;
    cfg_start = 1'b1;
    slv_word = DW'($urandom);
    do_read(slv_word, 1, got, falls, pulses, hicyc);
    cfg_start = 1'b0;
    chk("held_start_read_data", 32'(got), 32'(model_read(slv_word)));
    chk("held_start_no_mosi", 32'(mosi_hi - m0), 0);
    chk("held_start_one_frame", 32'(ss_rises - s0), 1);
    b0 = busy_hi; s0 = ss_rises;
    pulse_cfg_start();
    repeat (20) @(negedge clk);
    chk("late_start_no_busy", 32'(busy_hi - b0), 0);
    chk("late_start_no_ss", 32'(ss_rises - s0), 0);

    // ---- reset at bit 7 of the gyro word ----
    n_rst = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    chk("rereset_configured_clear", 32'(configured_out), 0);
    for (int i = 0; i < NW; i++) cfg_w[i] = DW'($urandom);
    set_cfg();
    f0 = fall_cnt; r0 = rise_cnt; p0 = rv_pulses;
    pulse_cfg_start();
    for (k = 0; k < 3000 && (fall_cnt - f0) < DW + 8; k++) @(negedge clk);
    chk("gyro_bit7_wait", 32'(k < 3000), 1);
    @(negedge clk);
    chk("gyro_bit7_rises", 32'(rise_cnt - r0), DW + 8);
    #2 n_rst = 1'b0;
    #1;
    chk("midreset_ctrl_outputs", 32'({sclk_out, mosi_out, ss_out, busy_out, configured_out, rd_valid_out}), 0);
    chk("midreset_rd_data", 32'(rd_data_out), 0);
    @(negedge clk);
    n_rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("midreset_no_valid", 32'(rv_pulses - p0), 0);
    for (int i = 0; i < NW; i++) cfg_w[i] = DW'($urandom);
    set_cfg();
    base = cap_q.size();
    pulse_cfg_start();
    wait_configured("resend");
    check_words("resend_cfg", base);
    slv_word = DW'($urandom);
    do_read(slv_word, 0, got, falls, pulses, hicyc);
    chk("post_resend_read", 32'(got), 32'(model_read(slv_word)));

`ifdef KF_SPI_MASTER_TIMEOUT_EN
    // ---- WAIT_READY watchdog ----
    p0 = rv_pulses;
    read_en = 1'b1;
    for (k = 0; k < 10 && !busy_out; k++) @(negedge clk);
    chk("timeout_busy_wait", 32'(busy_out), 1);
    for (k = 0; k < 5000 && !timeout_out; k++) @(negedge clk);
    chk("timeout_cycle", 32'(k), 4096);
    read_en = 1'b0;
    @(negedge clk);
    chk("timeout_single_pulse", 32'(timeout_out), 0);
    for (k = 0; k < 20 && busy_out; k++) @(negedge clk);
    chk("timeout_back_idle", 32'(busy_out), 0);
    chk("timeout_no_valid", 32'(rv_pulses - p0), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
